// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit serial frames into single-cycle register
// read/write strobes. All SPI pins are oversampled in the clk domain.
`timescale 1ns/1ps
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);

  typedef enum logic [2:0] {IDLE, CMD, RREQ, RCAP, RDATA, WDATA, WREQ, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_p1;
  logic                   sclk_s, cs_n_s, mosi_s, sclk_rise, sclk_fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx, tx, rx_next;
  logic                   armed, rd_vld_p1;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p1;
  assign sclk_fall = ~sclk_s & sclk_p1;
  assign rx_next   = {rx[6:0], mosi_s};

  // cs_n sync resets to 0 so a frame cannot start until cs_n is genuinely seen high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_p1   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_p1   <= sclk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx         <= '0;
      tx         <= '0;
      armed      <= 1'b0;
      rd_vld_p1  <= 1'b0;
      miso       <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      data_write <= '0;
    end else begin
      read      <= 1'b0;
      write     <= 1'b0;
      rd_vld_p1 <= read;
      if (cs_n_s) armed <= 1'b1;
      if (cs_n_s) begin
        state   <= IDLE;
        miso    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (armed) begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (sclk_rise) begin
            rx      <= rx_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              addr  <= rx_next[5:0];
              state <= rx_next[7] ? WDATA : RREQ;
            end
          end
          RREQ: begin
            read  <= 1'b1;
            state <= RCAP;
          end
          // data_read is valid the cycle after the read strobe, tracked by rd_vld_p1
          RCAP: if (rd_vld_p1) begin
            miso    <= data_read[7];
            tx      <= {data_read[6:0], 1'b0};
            bit_cnt <= '0;
            state   <= RDATA;
          end
          // the fall that follows the last command rise is skipped via bit_cnt == 0
          RDATA: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= DONE;
                miso  <= 1'b0;
              end
            end else if (sclk_fall && bit_cnt != 3'd0) begin
              miso <= tx[7];
              tx   <= {tx[6:0], 1'b0};
            end
          end
          WDATA: if (sclk_rise) begin
            rx      <= rx_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= WREQ;
          end
          WREQ: begin
            data_write <= rx;
            write      <= 1'b1;
            state      <= DONE;
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected strobes are queued as frames are
// driven and popped as the DUT issues read/write strobes.
`timescale 1ns/1ps
module tb_spi_reg_bridge;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, read, write;
  logic [5:0] addr;
  logic [7:0] data_write, data_read;

  always #5 clk = ~clk;

  spi_reg_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read)
  );

  typedef struct packed {
    logic       rw;
    logic [5:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  int         n_strobes = 0;
  logic [7:0] env_regs [64] = '{13: 8'h3C, default: 8'h00};
  logic [7:0] exp_regs [64] = '{13: 8'h3C, default: 8'h00};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // register file model: data_read valid exactly one clk after the read strobe
  always @(posedge clk) begin
    data_read <= read ? env_regs[addr] : 8'hE7;
    if (write) env_regs[addr] <= data_write;
  end

  always @(negedge clk) begin : mon
    txn_t e;
    if (read || write) begin
      n_strobes++;
      check("rw_excl", {31'd0, read & write}, 32'd0);
      if (sb_q.size() == 0) begin
        check("sb_unexpected", {30'd0, read, write}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_rw", {31'd0, write}, {31'd0, e.rw});
        check("sb_addr", {26'd0, addr}, {26'd0, e.addr});
        if (e.rw) check("sb_data", {24'd0, data_write}, {24'd0, e.data});
      end
    end
  end

  task automatic expect_write(input logic [5:0] a, input logic [7:0] d);
    sb_q.push_back(txn_t'{rw: 1'b1, addr: a, data: d});
    exp_regs[a] = d;
  endtask

  task automatic expect_read(input logic [5:0] a);
    sb_q.push_back(txn_t'{rw: 1'b0, addr: a, data: 8'h00});
  endtask

  task automatic xfer_bits(input logic [31:0] data, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      #HALF;
      sclk = 1'b1;
      rx = {rx[30:0], miso};
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    cs_n = 1'b1;
    mosi = 1'b0;
    #(2 * HALF);
  endtask

  task automatic frame(input logic [31:0] data, input int nbits, output logic [31:0] rx);
    cs_low();
    xfer_bits(data, nbits, rx);
    cs_high();
  endtask

  initial begin
    logic [31:0] rx;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_addr", {26'd0, addr}, 32'd0);
    check("rst_wdata", {24'd0, data_write}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    expect_write(6'h03, 8'hA5);
    frame(32'h83A5, 16, rx);
    check("idle_miso_w", {31'd0, miso}, 32'd0);

    expect_read(6'h0D);
    frame(32'h0D00, 16, rx);
    check("rd_miso_0d", {24'd0, rx[7:0]}, {24'd0, exp_regs[13]});
    check("idle_miso_r", {31'd0, miso}, 32'd0);

    // aborted write: only 12 of the 16 bits of 0x85FF
    cs_low();
    xfer_bits(32'h85FF >> 4, 12, rx);
    cs_high();
    expect_write(6'h05, 8'h12);
    frame(32'h8512, 16, rx);

    expect_write(6'h00, 8'h34);
    frame(32'h8034, 16, rx);
    expect_read(6'h00);
    frame(32'h0000, 16, rx);
    check("rd_miso_b2b", {24'd0, rx[7:0]}, {24'd0, exp_regs[0]});

    // reset in the middle of byte1 of a write, cs_n held low throughout
    cs_low();
    xfer_bits(32'h8177 >> 4, 12, rx);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_read", {31'd0, read}, 32'd0);
    check("mid_rst_write", {31'd0, write}, 32'd0);
    check("mid_rst_addr", {26'd0, addr}, 32'd0);
    check("mid_rst_wdata", {24'd0, data_write}, 32'd0);
    check("mid_rst_miso", {31'd0, miso}, 32'd0);
    rst_n = 1'b1;
    xfer_bits(32'h7, 4, rx);
    cs_high();
    expect_write(6'h03, 8'h5C);
    frame(32'h835C, 16, rx);

    expect_write(6'h02, 8'h01);
    frame(32'h8201FF, 24, rx);

    expect_read(6'h03);
    frame(32'h0300, 16, rx);
    check("rd_miso_03", {24'd0, rx[7:0]}, {24'd0, exp_regs[3]});

    repeat (10) @(posedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    check("n_strobes", n_strobes, 32'd8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
